// File: rtl/mlp_pkg.sv
// Shared MLP definitions.
//   LANES          : default vector width (lanes per neuron) of the compute datapath
//   int8_t         : signed 8-bit operand type
//   loader_state_t : operand loader FSM states
package mlp_pkg;

  localparam int LANES = 8;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IN = 3'd1,
    LOAD_W  = 3'd2,
    LOAD_B  = 3'd3,
    DRAIN   = 3'd4,
    PRESENT = 3'd5
  } loader_state_t;

endpackage

// File: rtl/mlp_operand_loader_if.sv
// Operand loader bus: memory read port plus the operand-set handshake.
//   mem_rd_en / mem_addr : read request, one byte per cycle
//   mem_rd_data          : read data, valid exactly one cycle after mem_rd_en
//   data_out/weight_out/bias_out : operand set for one neuron
//   vec_valid / vec_ready        : operand-set handshake
//
// Handshake: a set is transferred on a cycle where vec_valid and vec_ready
// are both 1. While vec_valid=1 and vec_ready=0 the producer holds vec_valid
// and every operand stable. vec_ready may be high before vec_valid; it has
// no effect until vec_valid rises. vec_valid drops the cycle after transfer.
interface mlp_operand_loader_if #(
  parameter int ADDR_W = 12,
  parameter int LANES  = mlp_pkg::LANES
) ();

  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  mlp_pkg::int8_t      mem_rd_data;
  mlp_pkg::int8_t      data_out   [0:LANES-1];
  mlp_pkg::int8_t      weight_out [0:LANES-1];
  mlp_pkg::int8_t      bias_out;
  logic                vec_valid;
  logic                vec_ready;

  modport master (
    output mem_rd_en, mem_addr, data_out, weight_out, bias_out, vec_valid,
    input  mem_rd_data, vec_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, data_out, weight_out, bias_out, vec_valid,
    output mem_rd_data, vec_ready
  );

endinterface

// File: rtl/mlp_operand_loader.sv
// Operand loader for one MLP layer. Fetches the shared input vector once,
// then per neuron fetches LANES weights and one bias, and presents the set
// to the compute datapath over a valid/ready handshake.
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle layer start (ignored while busy)
//   num_neurons   : neurons in the layer, latched at start
//   in_base/w_base/b_base : byte base addresses, latched at start
//   busy, done    : layer in progress / one-cycle completion pulse
//   state_dbg     : current FSM state
//   bus           : memory read port and operand-set handshake
module mlp_operand_loader #(
  parameter int ADDR_W = 12,
  parameter int LANES  = mlp_pkg::LANES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            num_neurons,
  input  logic [ADDR_W-1:0]     in_base,
  input  logic [ADDR_W-1:0]     w_base,
  input  logic [ADDR_W-1:0]     b_base,
  output logic                  busy,
  output logic                  done,
  output mlp_pkg::loader_state_t state_dbg,
  mlp_operand_loader_if.master  bus
);
  import mlp_pkg::*;

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);

  loader_state_t     state, state_n;
  logic [PW-1:0]     iss_ptr, iss_ptr_n;
  logic [PW-1:0]     cap_ptr;
  logic              cap_en;
  loader_state_t     cap_src;
  logic [7:0]        num_q, neuron, neuron_n;
  logic [ADDR_W-1:0] in_base_q, b_base_q, w_ptr, w_ptr_n;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en, done_n, latch;
  int8_t             data_q   [0:LANES-1];
  int8_t             weight_q [0:LANES-1];
  int8_t             bias_q;

  always_comb begin
    state_n   = state;
    iss_ptr_n = iss_ptr;
    neuron_n  = neuron;
    w_ptr_n   = w_ptr;
    done_n    = 1'b0;
    latch     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_neurons != 8'd0) begin
            latch     = 1'b1;
            state_n   = LOAD_IN;
            iss_ptr_n = '0;
            neuron_n  = 8'd0;
            w_ptr_n   = w_base;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      LOAD_IN: begin
        rd_en     = 1'b1;
        rd_addr   = in_base_q + ADDR_W'(iss_ptr);
        iss_ptr_n = iss_ptr + PW'(1);
        if (iss_ptr == LAST_LANE) begin
          iss_ptr_n = '0;
          state_n   = LOAD_W;
        end
      end
      LOAD_W: begin
        // Weight rows are contiguous, so one running pointer walks the
        // whole matrix across neurons; ADDR_W-bit arithmetic wraps silently.
        rd_en     = 1'b1;
        rd_addr   = w_ptr;
        w_ptr_n   = w_ptr + ADDR_W'(1);
        iss_ptr_n = iss_ptr + PW'(1);
        if (iss_ptr == LAST_LANE) begin
          iss_ptr_n = '0;
          state_n   = LOAD_B;
        end
      end
      LOAD_B: begin
        rd_en   = 1'b1;
        rd_addr = b_base_q + ADDR_W'(neuron);
        state_n = DRAIN;
      end
      DRAIN: begin
        // Bias byte is on mem_rd_data this cycle and captured at its end.
        state_n = PRESENT;
      end
      PRESENT: begin
        if (bus.vec_ready) begin
          if (neuron == num_q - 8'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            neuron_n = neuron + 8'd1;
            state_n  = LOAD_W;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      iss_ptr   <= '0;
      cap_ptr   <= '0;
      cap_en    <= 1'b0;
      cap_src   <= IDLE;
      num_q     <= 8'd0;
      neuron    <= 8'd0;
      in_base_q <= '0;
      b_base_q  <= '0;
      w_ptr     <= '0;
      done      <= 1'b0;
      bias_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        data_q[i]   <= '0;
        weight_q[i] <= '0;
      end
    end else begin
      state   <= state_n;
      iss_ptr <= iss_ptr_n;
      neuron  <= neuron_n;
      w_ptr   <= w_ptr_n;
      done    <= done_n;
      // Capture side trails the issue side by the one-cycle read latency.
      cap_en  <= rd_en;
      cap_src <= state;
      cap_ptr <= iss_ptr;
      if (latch) begin
        num_q     <= num_neurons;
        in_base_q <= in_base;
        b_base_q  <= b_base;
      end
      if (cap_en) begin
        case (cap_src)
          LOAD_IN: data_q[cap_ptr]   <= bus.mem_rd_data;
          LOAD_W:  weight_q[cap_ptr] <= bus.mem_rd_data;
          LOAD_B:  bias_q            <= bus.mem_rd_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = rd_addr;
  assign bus.vec_valid  = (state == PRESENT);
  assign bus.data_out   = data_q;
  assign bus.weight_out = weight_q;
  assign bus.bias_out   = bias_q;
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: doc/mlp_operand_loader.md
MLP_OPERAND_LOADER -- requirements
Module: mlp_operand_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, operand memory byte-address width.
REQ-002 SHALL have parameter LANES, default 8, vector lanes per neuron; must match the compute datapath.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle layer-start request.
REQ-006 SHALL have port num_neurons, input, 8, neurons in the layer; latched at start.
REQ-007 SHALL have ports in_base, w_base, b_base, input, ADDR_W each, base addresses of the input vector, weight matrix and bias array; latched at start.
REQ-008 SHALL have port mem_rd_en, output, 1, read strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W, read address.
REQ-010 SHALL have port mem_rd_data, input, signed 8, read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have ports data_out[0:LANES-1] and weight_out[0:LANES-1], output, signed 8 each, operand vectors to the compute datapath.
REQ-012 SHALL have port bias_out, output, signed 8, bias for the current neuron.
REQ-013 SHALL have port vec_valid, output, 1, operand set complete and stable.
REQ-014 SHALL have port vec_ready, input, 1, consumer accepts the set.
REQ-015 SHALL have port busy, output, 1, layer in progress.
REQ-016 SHALL have port done, output, 1, one-cycle layer-complete pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_IN, LOAD_W, LOAD_B, DRAIN, PRESENT.
REQ-018 SHALL, in IDLE with start=1 and num_neurons>0, latch the bases and count, set busy and enter LOAD_IN.
REQ-019 SHALL, in IDLE with start=1 and num_neurons=0, pulse done the next cycle, issue no reads and keep busy=0.
REQ-020 SHALL ignore start whenever busy=1.
REQ-021 SHALL in LOAD_IN read in_base+0..LANES-1 on consecutive cycles, once per layer; data_out is shared by all neurons.
REQ-022 SHALL in LOAD_W read w_base + n*LANES + 0..LANES-1 for neuron n (0-based).
REQ-023 SHALL in LOAD_B read b_base+n, then hold one DRAIN cycle to capture the final byte.
REQ-024 SHALL keep mem_rd_en asserted continuously from the first read to the last read of each fetch burst.
REQ-025 SHALL capture mem_rd_data into the lane addressed by a capture pointer delayed one cycle from the issue pointer.
REQ-026 SHALL compute all addresses modulo 2^ADDR_W, with silent wrap.
REQ-027 SHALL, for neuron 0, assert mem_rd_en for exactly 17 cycles starting 1 cycle after start is sampled, and raise vec_valid 19 cycles after start is sampled.
REQ-028 SHALL, for neuron n>0, assert mem_rd_en for exactly 9 cycles starting 1 cycle after the previous handshake, and raise vec_valid 11 cycles after that handshake.
REQ-029 SHALL complete a handshake on a cycle with vec_valid=1 and vec_ready=1; vec_ready before vec_valid has no effect.
REQ-030 SHALL hold vec_valid, data_out, weight_out and bias_out stable while vec_valid=1 and vec_ready=0.
REQ-031 SHALL deassert vec_valid in the cycle after a handshake.
REQ-032 SHALL keep mem_rd_en=0 in PRESENT and IDLE.
REQ-033 SHALL, on the handshake of neuron num_neurons-1, return to IDLE, pulse done for 1 cycle the next cycle and drop busy that same cycle.

Reset
REQ-034 SHALL on rst=1 set state IDLE, vec_valid=0, busy=0, done=0, mem_rd_en=0, mem_addr=0, all data_out/weight_out/bias_out=0, and all counters to 0.
REQ-035 SHALL, when rst asserts mid-burst or mid-present, abandon the layer with no done pulse; the next start after rst deasserts begins cleanly.

Structure
REQ-036 SHALL take from shared package mlp_pkg: LANES constant, int8 data typedef, loader state enum.
REQ-037 SHALL be a single module with no sub-modules; the FSM, issue/capture counters and neuron counter are all internal.

Verification
REQ-038 SHALL test a 1-byte-latency memory model with byte i = i[7:0] signed, bases 0/16/80, num_neurons=1 -> data_out=0..7, weight_out=16..23, bias_out=80, vec_valid 19 cycles after start, done 1 cycle after handshake.
REQ-039 SHALL test num_neurons=3 with vec_ready held 1 -> three sets with weights from w_base+0, +8, +16; handshakes spaced 11 cycles apart; exactly 17+9+9=35 reads.
REQ-040 SHALL test backpressure: vec_ready=0 for 20 cycles during PRESENT -> outputs unchanged every cycle; mem_rd_en=0 throughout.
REQ-041 SHALL test num_neurons=0 -> done pulse the next cycle, zero reads, busy never high; start during busy -> ignored, read count unchanged.
REQ-042 SHALL test wrap: w_base=4092 with ADDR_W=12 -> weight addresses 4092..4095, 0..3.
REQ-043 SHALL test reset mid-LOAD_W -> all outputs 0 the next cycle and no done pulse; a following start produces the correct first set.
